// File: rtl/hd_loader.sv
// ---------------------------------------------------------------------------
// hd_loader
//
// Sequential copy engine. Copies a contiguous block of words from the HD
// storage array into instruction/data memory, one word at a time. For each
// word the HD read address is held for RD_LATENCY cycles, the registered HD
// data is then captured and written to memory with a one-cycle strobe.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   reset     synchronous, active-high
//   start     transfer request, sampled only while idle
//   hd_base   first HD word address to read
//   mem_base  first memory word address to write
//   length    number of words to copy (0..2^HD_ADDR_WIDTH)
//   hd_addr   HD read address
//   hd_q      HD read data
//   mem_addr  memory write address
//   mem_data  memory write data
//   mem_we    one-cycle memory write strobe
//   busy      transfer in progress
//   done      one-cycle completion pulse
//   count     words written in the current/last transfer
// ---------------------------------------------------------------------------
module hd_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int HD_ADDR_WIDTH  = 12,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int RD_LATENCY     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [HD_ADDR_WIDTH-1:0]  hd_base,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_base,
    input  logic [HD_ADDR_WIDTH:0]    length,
    output logic [HD_ADDR_WIDTH-1:0]  hd_addr,
    input  logic [DATA_WIDTH-1:0]     hd_q,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_data,
    output logic                      mem_we,
    output logic                      busy,
    output logic                      done,
    output logic [HD_ADDR_WIDTH:0]    count
);

    localparam int LAT_W = 3;  // enough for RD_LATENCY up to 7
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state_q,    state_d;
    logic [LAT_W-1:0]          lat_q,      lat_d;
    logic [HD_ADDR_WIDTH-1:0]  hd_addr_q,  hd_addr_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_base_q, mem_base_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]     mem_data_q, mem_data_d;
    logic                      mem_we_q,   mem_we_d;
    logic                      busy_q,     busy_d;
    logic                      done_q,     done_d;
    logic [HD_ADDR_WIDTH:0]    len_q,      len_d;
    logic [HD_ADDR_WIDTH:0]    count_q,    count_d;

    // Word index within the block equals the number of words already written,
    // truncated to the memory address width so the target wraps naturally.
    logic [MEM_ADDR_WIDTH-1:0] word_idx;
    assign word_idx = MEM_ADDR_WIDTH'(count_q);

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can leave
        // a variable unassigned and infer a latch.
        state_d    = state_q;
        lat_d      = lat_q;
        hd_addr_d  = hd_addr_q;
        mem_base_d = mem_base_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;   // strobe and pulse are single-cycle by default
        done_d     = 1'b0;
        busy_d     = busy_q;
        len_d      = len_q;
        count_d    = count_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mem_base_d = mem_base;
                    len_d      = length;
                    count_d    = '0;
                    lat_d      = '0;
                    if (length == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_READ;
                        hd_addr_d = hd_base;
                        busy_d    = 1'b1;
                    end
                end
            end

            S_READ: begin
                // The edge ending the RD_LATENCY-th cycle since hd_addr moved
                // is the one that captures hd_q.
                if (lat_q == LAT_LAST) begin
                    mem_data_d = hd_q;
                    mem_addr_d = mem_base_q + word_idx;
                    mem_we_d   = 1'b1;
                    state_d    = S_WRITE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            S_WRITE: begin
                count_d = count_q + 1'b1;
                lat_d   = '0;
                if (count_d == len_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d   = S_READ;
                    hd_addr_d = hd_addr_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= S_IDLE;
            lat_q      <= '0;
            hd_addr_q  <= '0;
            mem_base_q <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            len_q      <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            hd_addr_q  <= hd_addr_d;
            mem_base_q <= mem_base_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            len_q      <= len_d;
            count_q    <= count_d;
        end
    end

    assign hd_addr  = hd_addr_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_we   = mem_we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;

endmodule

// File: tb/tb_hd_loader.sv
// ---------------------------------------------------------------------------
// tb_hd_loader
//
// Two loader instances: dut_a with RD_LATENCY=2 (HD modelled with one
// registered read stage) and dut_b with RD_LATENCY=1 (HD modelled as an
// asynchronous read). Stimulus pushes the expected writes (address, data,
// edge number) into per-instance queues; monitors pop and compare on every
// mem_we.
// ---------------------------------------------------------------------------
module tb_hd_loader;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          at_edge;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;  // number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- instance A: RD_LATENCY = 2 ----------------
    logic        reset_a, start_a;
    logic [11:0] hd_base_a, hd_addr_a;
    logic [9:0]  mem_base_a, mem_addr_a;
    logic [12:0] length_a, count_a;
    logic [31:0] hd_q_a, mem_data_a;
    logic        mem_we_a, busy_a, done_a;
    logic [31:0] hd_mem_a [4096];

    always @(posedge clk) hd_q_a <= hd_mem_a[hd_addr_a];

    hd_loader #(.DATA_WIDTH(32), .HD_ADDR_WIDTH(12), .MEM_ADDR_WIDTH(10), .RD_LATENCY(2)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a),
        .hd_base(hd_base_a), .mem_base(mem_base_a), .length(length_a),
        .hd_addr(hd_addr_a), .hd_q(hd_q_a),
        .mem_addr(mem_addr_a), .mem_data(mem_data_a), .mem_we(mem_we_a),
        .busy(busy_a), .done(done_a), .count(count_a)
    );

    // ---------------- instance B: RD_LATENCY = 1 ----------------
    logic        reset_b, start_b;
    logic [11:0] hd_base_b, hd_addr_b;
    logic [9:0]  mem_base_b, mem_addr_b;
    logic [12:0] length_b, count_b;
    logic [31:0] hd_q_b, mem_data_b;
    logic        mem_we_b, busy_b, done_b;
    logic [31:0] hd_mem_b [4096];

    assign hd_q_b = hd_mem_b[hd_addr_b];

    hd_loader #(.DATA_WIDTH(32), .HD_ADDR_WIDTH(12), .MEM_ADDR_WIDTH(10), .RD_LATENCY(1)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b),
        .hd_base(hd_base_b), .mem_base(mem_base_b), .length(length_b),
        .hd_addr(hd_addr_b), .hd_q(hd_q_b),
        .mem_addr(mem_addr_b), .mem_data(mem_data_b), .mem_we(mem_we_b),
        .busy(busy_b), .done(done_b), .count(count_b)
    );

    // ---------------- scoreboards / monitors ----------------
    wr_t exp_q_a[$];
    wr_t exp_q_b[$];
    int  done_cnt_a = 0;

    always @(negedge clk) begin
        wr_t w;
        if (done_a === 1'b1) done_cnt_a++;
        if (mem_we_a !== 1'b0) begin
            if (exp_q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_write: got addr 0x%0h data 0x%0h, expected no write (edge %0d)",
                         mem_addr_a, mem_data_a, cyc);
            end else begin
                w = exp_q_a.pop_front();
                check("a_wr_addr", 64'(mem_addr_a), 64'(w.addr));
                check("a_wr_data", 64'(mem_data_a), 64'(w.data));
                check("a_wr_edge", 64'(cyc), 64'(w.at_edge));
            end
        end
    end

    always @(negedge clk) begin
        wr_t w;
        if (mem_we_b !== 1'b0) begin
            if (exp_q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_write: got addr 0x%0h data 0x%0h, expected no write (edge %0d)",
                         mem_addr_b, mem_data_b, cyc);
            end else begin
                w = exp_q_b.pop_front();
                // One combined comparison per word keeps the 4096-word run compact.
                check("b_wr", {mem_addr_b, mem_data_b, 22'(cyc)}, {w.addr, w.data, 22'(w.at_edge)});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check_reset_a(input string tag);
        check({tag, "_hd_addr"},  64'(hd_addr_a),  64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr_a), 64'd0);
        check({tag, "_mem_data"}, 64'(mem_data_a), 64'd0);
        check({tag, "_mem_we"},   64'(mem_we_a),   64'd0);
        check({tag, "_busy"},     64'(busy_a),     64'd0);
        check({tag, "_done"},     64'(done_a),     64'd0);
        check({tag, "_count"},    64'(count_a),    64'd0);
    endtask

    // Runs one transfer on instance A. With poke set, start is pulsed with
    // different operands mid-transfer and again during the done cycle.
    task automatic run_a(input logic [11:0] hb, input logic [9:0] mb, input logic [12:0] len, input bit poke);
        int  e0;
        bit  seen;
        wr_t w;
        @(negedge clk);
        hd_base_a  = hb;
        mem_base_a = mb;
        length_a   = len;
        start_a    = 1'b1;
        e0 = cyc + 1;
        for (int i = 0; i < int'(len); i++) begin
            w.addr    = mb + 10'(i);
            w.data    = hd_mem_a[hb + 12'(i)];
            w.at_edge = e0 + i * 3 + 2;
            exp_q_a.push_back(w);
        end
        @(negedge clk);
        start_a = 1'b0;
        check("a_busy_after_start", 64'(busy_a), 64'(len != 0));
        if (len != 0) check("a_hd_addr_first", 64'(hd_addr_a), 64'(hb));
        seen = 1'b0;
        for (int k = 0; k < int'(len) * 3 + 6; k++) begin
            if (done_a === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (poke && k == 2) begin
                start_a    = 1'b1;
                hd_base_a  = hb + 12'h111;
                mem_base_a = mb + 10'h0AA;
                length_a   = 13'd7;
            end else begin
                start_a = 1'b0;
            end
            @(negedge clk);
        end
        start_a = 1'b0;
        check("a_done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check("a_done_edge", 64'(cyc), 64'(e0 + int'(len) * 3));
            check("a_done_busy", 64'(busy_a), 64'd0);
            check("a_done_count", 64'(count_a), 64'(len));
            if (poke) begin
                start_a    = 1'b1;
                hd_base_a  = hb + 12'h222;
                mem_base_a = mb + 10'h155;
                length_a   = 13'd2;
            end
            @(negedge clk);
            start_a = 1'b0;
            check("a_done_one_cycle", 64'(done_a), 64'd0);
            check("a_idle_busy", 64'(busy_a), 64'd0);
            check("a_idle_count_hold", 64'(count_a), 64'(len));
            repeat (4) @(negedge clk);
            check("a_still_idle", 64'(busy_a), 64'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  e0;
        int  d0;
        bit  seen;
        wr_t w;

        for (int i = 0; i < 4096; i++) begin
            hd_mem_a[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0003);
            hd_mem_b[i] = 32'(i) * 32'h9E37_79B1;
        end
        hd_mem_a[0] = 32'h07C0_0020;
        hd_mem_a[1] = 32'h07BE_0000;
        hd_mem_a[2] = 32'h3800_01A0;

        reset_a = 1'b1; start_a = 1'b0; hd_base_a = '0; mem_base_a = '0; length_a = '0;
        reset_b = 1'b1; start_b = 1'b0; hd_base_b = '0; mem_base_b = '0; length_b = '0;
        repeat (2) @(negedge clk);
        reset_a = 1'b0;
        reset_b = 1'b0;
        check_reset_a("por");

        // Basic load with start pulses mid-transfer and in the done cycle.
        run_a(12'h000, 10'h010, 13'd3, 1'b1);

        // A new start right after done is accepted (zero-length case).
        run_a(12'h123, 10'h055, 13'd0, 1'b0);

        // Reset held two cycles while idle with non-zero mem regs beforehand.
        run_a(12'h400, 10'h2A0, 13'd1, 1'b0);
        @(negedge clk);
        reset_a = 1'b1;
        repeat (2) @(negedge clk);
        reset_a = 1'b0;
        check_reset_a("idle_rst");

        // Reset during word 2 of a 5-word transfer: only words 0 and 1 land.
        @(negedge clk);
        hd_base_a = 12'h010; mem_base_a = 10'h100; length_a = 13'd5; start_a = 1'b1;
        e0 = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            w.addr    = 10'h100 + 10'(i);
            w.data    = hd_mem_a[12'h010 + 12'(i)];
            w.at_edge = e0 + i * 3 + 2;
            exp_q_a.push_back(w);
        end
        @(negedge clk);
        start_a = 1'b0;
        while (cyc < e0 + 7) @(negedge clk);
        reset_a = 1'b1;
        d0 = done_cnt_a;
        @(negedge clk);
        reset_a = 1'b0;
        check_reset_a("mid_rst");
        repeat (30) @(negedge clk);
        check("mid_rst_no_done", 64'(done_cnt_a), 64'(d0));
        check("mid_rst_queue_empty", 64'(exp_q_a.size()), 64'd0);

        // Wrap of both address spaces.
        run_a(12'hFFF, 10'h3FF, 13'd2, 1'b0);

        // Full 4096-word load at RD_LATENCY=1.
        @(negedge clk);
        hd_base_b = 12'h080; mem_base_b = 10'h200; length_b = 13'd4096; start_b = 1'b1;
        e0 = cyc + 1;
        for (int i = 0; i < 4096; i++) begin
            w.addr    = 10'h200 + 10'(i);
            w.data    = hd_mem_b[12'h080 + 12'(i)];
            w.at_edge = e0 + i * 2 + 1;
            exp_q_b.push_back(w);
        end
        @(negedge clk);
        start_b = 1'b0;
        check("b_busy_after_start", 64'(busy_b), 64'd1);
        seen = 1'b0;
        for (int k = 0; k < 4096 * 2 + 10; k++) begin
            if (done_b === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("b_done_seen", 64'(seen), 64'd1);
        check("b_done_edge", 64'(cyc), 64'(e0 + 4096 * 2));
        check("b_count", 64'(count_b), 64'd4096);
        check("b_last_hd_addr", 64'(hd_addr_b), 64'h07F);
        check("b_busy_at_done", 64'(busy_b), 64'd0);
        @(negedge clk);
        check("b_queue_empty", 64'(exp_q_b.size()), 64'd0);
        check("a_queue_empty", 64'(exp_q_a.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
